// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile write-back arbiter.
// Latency and backpressure are not applicable here; this package holds only definitions.
package regfile_wb_arbiter_pkg;

  localparam int REG_BUS       = 64;
  localparam int REG_NUM       = 32;
  localparam int WB_FIFO_DEPTH = 4;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG0 = 5'd0;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LSU,
    WB_SRC_FIFO,
    WB_SRC_EXU
  } wb_src_e;

  function automatic logic [REG_NUM-1:0] idx_onehot(input reg_idx_t idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Decode / EXU / LSU / regfile-write bundle of the write-back arbiter; slave is the arbiter's view.
// Forwarding outputs exist only when WB_FWD_EN is defined; the bundle itself adds no latency.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = REG_BUS
);

  logic            iss_valid;
  reg_idx_t        iss_rd;
  logic            exu_valid;
  logic            exu_ready;
  reg_idx_t        exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  reg_idx_t        lsu_rd;
  logic [XLEN-1:0] lsu_data;
  reg_idx_t        rs1;
  reg_idx_t        rs2;
  logic            busy_rs1;
  logic            busy_rs2;
  logic            busy_rd;
  logic            wb_en;
  reg_idx_t        wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            err_waw;
`ifdef WB_FWD_EN
  logic            fwd_hit1;
  logic            fwd_hit2;
  logic [XLEN-1:0] fwd_data;
`endif

  modport slave (
    input  iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    output exu_ready, lsu_ready, busy_rs1, busy_rs2, busy_rd,
    output wb_en, wb_rd, wb_data, err_waw
`ifdef WB_FWD_EN
    , output fwd_hit1, fwd_hit2, fwd_data
`endif
  );

  modport master (
    output iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    input  exu_ready, lsu_ready, busy_rs1, busy_rs2, busy_rd,
    input  wb_en, wb_rd, wb_data, err_waw
`ifdef WB_FWD_EN
    , input fwd_hit1, fwd_hit2, fwd_data
`endif
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Generic DEPTH x W result FIFO with wrapping pointers; read data is the combinational head.
// Latency: a push is visible at the head next cycle; backpressure: push ignored when full, pop ignored when empty.
module wb_result_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Serialises EXU/LSU results into one registered regfile write per cycle and tracks pending rds.
// Latency 1 cycle accept->wb_en; LSU never stalls, EXU stalls on full FIFO; WB_FWD_EN adds forwarding.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN  = REG_BUS,
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int EW = $bits(reg_idx_t) + XLEN;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [EW-1:0]      fifo_head;
  wb_src_e            src;
  reg_idx_t           nxt_rd;
  logic [XLEN-1:0]    nxt_data;
  logic               wb_en_q;
  reg_idx_t           wb_rd_q;
  logic [XLEN-1:0]    wb_data_q;
  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pend_set;
  logic [REG_NUM-1:0] pend_clr;
  logic               err_q;
  logic               busy_rd_c;
  logic               hit1;
  logic               hit2;

  wb_result_fifo #(
    .W    (EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_dat({bus.exu_rd, bus.exu_data}),
    .pop     (fifo_pop),
    .pop_dat (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // LSU first, then the oldest queued EXU result, then an EXU beat straight through an empty FIFO.
  always_comb begin
    src      = WB_SRC_NONE;
    nxt_rd   = REG0;
    nxt_data = '0;
    if (bus.lsu_valid) begin
      src      = WB_SRC_LSU;
      nxt_rd   = bus.lsu_rd;
      nxt_data = bus.lsu_data;
    end else if (!fifo_empty) begin
      src                = WB_SRC_FIFO;
      {nxt_rd, nxt_data} = fifo_head;
    end else if (bus.exu_valid) begin
      src      = WB_SRC_EXU;
      nxt_rd   = bus.exu_rd;
      nxt_data = bus.exu_data;
    end
  end

  assign fifo_push = bus.exu_valid && !fifo_full && (src != WB_SRC_EXU);
  assign fifo_pop  = (src == WB_SRC_FIFO);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= REG0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= (src != WB_SRC_NONE) && (nxt_rd != REG0);
      if (src != WB_SRC_NONE) begin
        wb_rd_q   <= nxt_rd;
        wb_data_q <= nxt_data;
      end
    end
  end

  // Clear is applied before set so a same-cycle reissue of the retiring rd stays pending.
  assign pend_set  = (bus.iss_valid && bus.iss_rd != REG0) ? idx_onehot(bus.iss_rd) : '0;
  assign pend_clr  = wb_en_q ? idx_onehot(wb_rd_q) : '0;
  assign busy_rd_c = pending[bus.iss_rd] && (bus.iss_rd != REG0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      err_q   <= 1'b0;
    end else begin
      pending <= (pending & ~pend_clr) | pend_set;
      err_q   <= err_q | (bus.iss_valid && busy_rd_c);
    end
  end

`ifdef WB_FWD_EN
  assign hit1         = wb_en_q && (wb_rd_q == bus.rs1) && (bus.rs1 != REG0);
  assign hit2         = wb_en_q && (wb_rd_q == bus.rs2) && (bus.rs2 != REG0);
  assign bus.fwd_hit1 = hit1;
  assign bus.fwd_hit2 = hit2;
  assign bus.fwd_data = wb_data_q;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign bus.busy_rs1  = pending[bus.rs1] && (bus.rs1 != REG0) && !hit1;
  assign bus.busy_rs2  = pending[bus.rs2] && (bus.rs2 != REG0) && !hit2;
  assign bus.busy_rd   = busy_rd_c;
  assign bus.exu_ready = !fifo_full;
  assign bus.lsu_ready = 1'b1;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.err_waw   = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_arbiter_if #(.XLEN(64)) bus ();

  regfile_wb_arbiter #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference state: queued EXU results, pending flags, sticky error, write expected this cycle.
  ent_t        q[$];
  bit          pend[32];
  bit          m_err;
  bit          m_en;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  bit          mvalid = 0;
  bit          exu_hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic b1, b2, br;
    if (!mvalid) return;
    b1 = pend[bus.rs1] && (bus.rs1 != 0);
    b2 = pend[bus.rs2] && (bus.rs2 != 0);
    br = pend[bus.iss_rd] && (bus.iss_rd != 0);
`ifdef WB_FWD_EN
    begin
      logic h1, h2;
      h1 = m_en && (m_rd == bus.rs1) && (bus.rs1 != 0);
      h2 = m_en && (m_rd == bus.rs2) && (bus.rs2 != 0);
      chk("fwd_hit1", bus.fwd_hit1, h1);
      chk("fwd_hit2", bus.fwd_hit2, h2);
      if (m_en) chk("fwd_data", bus.fwd_data, m_data);
      b1 = b1 && !h1;
      b2 = b2 && !h2;
    end
`endif
    chk("exu_ready", bus.exu_ready, q.size() < DEPTH);
    chk("lsu_ready", bus.lsu_ready, 1);
    chk("wb_en", bus.wb_en, m_en);
    if (m_en) begin
      chk("wb_rd", bus.wb_rd, m_rd);
      chk("wb_data", bus.wb_data, m_data);
    end
    chk("busy_rs1", bus.busy_rs1, b1);
    chk("busy_rs2", bus.busy_rs2, b2);
    chk("busy_rd", bus.busy_rd, br);
    chk("err_waw", bus.err_waw, m_err);
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    ent_t e;
    bit   acc;
    if (rst) begin
      q.delete();
      foreach (pend[i]) pend[i] = 0;
      m_err    = 0;
      m_en     = 0;
      m_rd     = '0;
      m_data   = '0;
      exu_hold = 0;
      mvalid   = 1;
      return;
    end
    if (bus.iss_valid && bus.iss_rd != 0 && pend[bus.iss_rd]) m_err = 1;
    if (m_en) pend[m_rd] = 0;
    if (bus.iss_valid && bus.iss_rd != 0) pend[bus.iss_rd] = 1;
    acc      = bus.exu_valid && (q.size() < DEPTH);
    exu_hold = bus.exu_valid && !acc;
    if (acc) begin
      e.rd   = bus.exu_rd;
      e.data = bus.exu_data;
      q.push_back(e);
    end
    if (bus.lsu_valid) begin
      m_en   = (bus.lsu_rd != 0);
      m_rd   = bus.lsu_rd;
      m_data = bus.lsu_data;
    end else if (q.size() > 0) begin
      e      = q.pop_front();
      m_en   = (e.rd != 0);
      m_rd   = e.rd;
      m_data = e.data;
    end else begin
      m_en = 0;
    end
  endtask

  task automatic cycle();
    #1;
    model_check();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.exu_valid = 1'b0;
    bus.exu_rd    = '0;
    bus.exu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
  endtask

  task automatic rand_inputs(input int lsu_pct);
    if (!exu_hold) begin
      bus.exu_valid = ($urandom_range(0, 99) < 60);
      bus.exu_rd    = 5'($urandom_range(0, 7));
      bus.exu_data  = {$urandom, $urandom};
    end
    bus.lsu_valid = ($urandom_range(0, 99) < lsu_pct);
    bus.lsu_rd    = 5'($urandom_range(0, 7));
    bus.lsu_data  = {$urandom, $urandom};
    bus.iss_valid = ($urandom_range(0, 99) < 30);
    bus.iss_rd    = 5'($urandom_range(0, 7));
    bus.rs1       = 5'($urandom_range(0, 7));
    bus.rs2       = 5'($urandom_range(0, 7));
  endtask

  initial begin
    int n;
    idle_inputs();

    // Reset held two cycles with every valid high.
    rst           = 1'b1;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd9;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd9;
    bus.rs1       = 5'd9;
    bus.rs2       = 5'd9;
    cycle();
    cycle();
    rst = 1'b0;
    idle_inputs();
    bus.rs1 = 5'd9;
    bus.rs2 = 5'd9;
    #1;
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_busy_rs1", bus.busy_rs1, 0);
    chk("rst_busy_rs2", bus.busy_rs2, 0);
    chk("rst_exu_ready", bus.exu_ready, 1);
    chk("rst_err", bus.err_waw, 0);
    cycle();

    // Single EXU result through the empty FIFO.
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    cycle();
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd5;
    bus.exu_data  = 64'h1234;
    bus.rs1       = 5'd5;
    #1 chk("single_busy_pre", bus.busy_rs1, 1);
    cycle();
    bus.exu_valid = 1'b0;
    #1;
    chk("single_wb_en", bus.wb_en, 1);
    chk("single_wb_rd", bus.wb_rd, 5);
    chk("single_wb_data", bus.wb_data, 64'h1234);
`ifdef WB_FWD_EN
    chk("single_busy_wb", bus.busy_rs1, 0);
`else
    chk("single_busy_wb", bus.busy_rs1, 1);
`endif
    cycle();
    #1;
    chk("single_wb_off", bus.wb_en, 0);
    chk("single_busy_post", bus.busy_rs1, 0);

    // EXU and LSU collide: LSU writes first.
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd3;
    bus.exu_data  = 64'hAA;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd4;
    bus.lsu_data  = 64'hBB;
    cycle();
    bus.exu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    #1;
    chk("coll_first_rd", bus.wb_rd, 4);
    chk("coll_first_data", bus.wb_data, 64'hBB);
    cycle();
    #1;
    chk("coll_second_en", bus.wb_en, 1);
    chk("coll_second_rd", bus.wb_rd, 3);
    chk("coll_second_data", bus.wb_data, 64'hAA);
    cycle();

    // LSU stream of six beats while EXU keeps offering: FIFO fills after four pushes.
    n = 0;
    bus.exu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.exu_rd   = 5'(8 + n);
      bus.exu_data = 64'h100 + 64'(n);
      bus.lsu_rd   = 5'(16 + i);
      bus.lsu_data = 64'h200 + 64'(i);
      #1 chk("full_exu_ready", bus.exu_ready, (i < 4) ? 1 : 0);
      if (bus.exu_ready) n++;
      cycle();
    end
    bus.lsu_valid = 1'b0;
    #1;
    chk("full_last_lsu_rd", bus.wb_rd, 21);
    chk("full_still_full", bus.exu_ready, 0);
    cycle();
    #1;
    chk("full_ready_again", bus.exu_ready, 1);
    chk("full_pop0_rd", bus.wb_rd, 8);
    chk("full_pop0_data", bus.wb_data, 64'h100);
    cycle();
    bus.exu_valid = 1'b0;
    for (int j = 1; j < 5; j++) begin
      #1;
      chk("full_pop_en", bus.wb_en, 1);
      chk("full_pop_rd", bus.wb_rd, 64'(8 + j));
      chk("full_pop_data", bus.wb_data, 64'h100 + 64'(j));
      cycle();
    end
    #1 chk("full_drained", bus.wb_en, 0);

    // Result to x0 is consumed without a write.
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd0;
    bus.exu_data  = 64'hFF;
    #1 chk("rd0_ready", bus.exu_ready, 1);
    cycle();
    bus.exu_valid = 1'b0;
    #1 chk("rd0_no_write", bus.wb_en, 0);
    cycle();

    // Double issue to rd 7 flags WAW, then its write-back.
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    cycle();
    #1 chk("waw_busy_rd", bus.busy_rd, 1);
    cycle();
    bus.iss_valid = 1'b0;
    #1 chk("waw_err", bus.err_waw, 1);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd7;
    bus.exu_data  = 64'h77;
    cycle();
    bus.exu_valid = 1'b0;
    bus.rs1       = 5'd7;
    #1;
`ifdef WB_FWD_EN
    chk("fwd_hit1_lit", bus.fwd_hit1, 1);
    chk("fwd_busy_rs1", bus.busy_rs1, 0);
`else
    chk("nofwd_busy_rs1", bus.busy_rs1, 1);
`endif
    cycle();

    // Random traffic with varying LSU pressure and a reset in the middle.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 600; c++) begin
        rand_inputs((ph == 0) ? 20 : (ph == 1) ? 75 : 40);
        cycle();
      end
      if (ph == 1) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("midrst_wb_en", bus.wb_en, 0);
        chk("midrst_exu_ready", bus.exu_ready, 1);
        chk("midrst_err", bus.err_waw, 0);
        cycle();
      end
    end

    idle_inputs();
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
